// File: rtl/placar_varredura_display.sv
// Scoreboard display driver for two team scores on a shared 4-digit,
// time-multiplexed 7-segment display. Each 7-bit score is converted to two
// BCD digits by sequential shift-and-add-3; both teams convert in parallel
// and their digits are latched into the display registers on one edge.
// The invalid-operation level is stretched into a fixed-length buzzer pulse.
//
// Handshake: atualizar is a one-cycle strobe with no ready. When the block
// is idle it starts a conversion at once. When ocupado=1 it is remembered
// in a one-deep pending flag, and further strobes merge into it. The scores
// are sampled when a conversion starts or restarts, not at the strobe.
module placar_varredura_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BUZZ_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] pontos_time0,
  input  logic [6:0] pontos_time1,
  input  logic       atualizar,
  input  logic       erro,
  output logic [6:0] segmentos,
  output logic [3:0] anodos,
  output logic       ocupado,
  output logic [1:0] estouro,
  output logic       buzzer
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, GRAVA} estado_t;

  estado_t     estado;
  logic [2:0]  passo;
  logic        pendente;
  logic [6:0]  sh0, sh1;
  logic [7:0]  bcd0, bcd1;
  logic        ovf0, ovf1;

  // Digits currently shown: tens/units of each team.
  logic [3:0]  dez0, uni0, dez1, uni1;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    dig_sel;
  logic          dig_blank;

  logic          erro_r, erro_p;
  logic [BW-1:0] buzz_cnt;

  // A BCD nibble of 5 or more gets +3 before the shift so it carries correctly.
  function automatic logic [3:0] ajusta(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Active-low segment code, bit0=a .. bit6=g; anything above 9 is blank.
  function automatic logic [6:0] codifica(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Conversion FSM: capture, 7 shift-and-add-3 steps, then atomic latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= OCIOSO;
      passo    <= 3'd0;
      pendente <= 1'b0;
      sh0      <= 7'd0;
      sh1      <= 7'd0;
      bcd0     <= 8'd0;
      bcd1     <= 8'd0;
      ovf0     <= 1'b0;
      ovf1     <= 1'b0;
      dez0     <= 4'd0;
      uni0     <= 4'd0;
      dez1     <= 4'd0;
      uni1     <= 4'd0;
      estouro  <= 2'b00;
      ocupado  <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (atualizar) begin
            sh0     <= pontos_time0;
            sh1     <= pontos_time1;
            ovf0    <= (pontos_time0 > 7'd99);
            ovf1    <= (pontos_time1 > 7'd99);
            bcd0    <= 8'd0;
            bcd1    <= 8'd0;
            passo   <= 3'd0;
            estado  <= CONVERTE;
            ocupado <= 1'b1;
          end
        end
        CONVERTE: begin
          if (atualizar) pendente <= 1'b1;
          bcd0 <= {ajusta(bcd0[7:4]), ajusta(bcd0[3:0])} << 1 | {7'd0, sh0[6]};
          bcd1 <= {ajusta(bcd1[7:4]), ajusta(bcd1[3:0])} << 1 | {7'd0, sh1[6]};
          sh0  <= sh0 << 1;
          sh1  <= sh1 << 1;
          if (passo == 3'd6) begin
            estado <= GRAVA;
          end else begin
            passo <= passo + 3'd1;
          end
        end
        GRAVA: begin
          // Scores of 100 and above cannot be shown; saturate at 99.
          dez0    <= ovf0 ? 4'd9 : bcd0[7:4];
          uni0    <= ovf0 ? 4'd9 : bcd0[3:0];
          dez1    <= ovf1 ? 4'd9 : bcd1[7:4];
          uni1    <= ovf1 ? 4'd9 : bcd1[3:0];
          estouro <= {ovf1, ovf0};
          // A strobe landing in this very cycle is treated like a pending one.
          if (pendente || atualizar) begin
            pendente <= 1'b0;
            sh0      <= pontos_time0;
            sh1      <= pontos_time1;
            ovf0     <= (pontos_time0 > 7'd99);
            ovf1     <= (pontos_time1 > 7'd99);
            bcd0     <= 8'd0;
            bcd1     <= 8'd0;
            passo    <= 3'd0;
            estado   <= CONVERTE;
          end else begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  // Pick the digit for the current scan position; a zero tens digit is blanked.
  always_comb begin
    dig_sel   = 4'd0;
    dig_blank = 1'b0;
    case (idx)
      2'd0: begin dig_sel = dez0; dig_blank = (dez0 == 4'd0); end
      2'd1: begin dig_sel = uni0; end
      2'd2: begin dig_sel = dez1; dig_blank = (dez1 == 4'd0); end
      default: begin dig_sel = uni1; end
    endcase
  end

  // Scan timer and registered anode/segment drive, updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      anodos    <= 4'b1111;
      segmentos <= 7'b1111111;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      anodos    <= ~(4'b0001 << idx);
      segmentos <= dig_blank ? 7'b1111111 : codifica(dig_sel);
    end
  end

  // Error edge detector and retriggerable buzzer down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erro_r   <= 1'b0;
      erro_p   <= 1'b0;
      buzz_cnt <= '0;
    end else begin
      erro_r <= erro;
      erro_p <= erro_r;
      if (erro_r && !erro_p) begin
        buzz_cnt <= BUZZ_LOAD;
      end else if (buzz_cnt != '0) begin
        buzz_cnt <= buzz_cnt - 1'b1;
      end
    end
  end

  assign buzzer = (buzz_cnt != '0);

endmodule

// File: tb/tb_placar_varredura_display.sv
// Directed bench for placar_varredura_display with a short scan period and
// a short buzzer pulse. Inputs are driven and outputs sampled on the falling
// clock edge.
module tb_placar_varredura_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] pontos_time0, pontos_time1;
  logic       atualizar, erro;
  logic [6:0] segmentos;
  logic [3:0] anodos;
  logic       ocupado;
  logic [1:0] estouro;
  logic       buzzer;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  logic [3:0] an_pat [4];
  logic [6:0] seg_rst [4];

  placar_varredura_display #(.REFRESH_DIV(4), .BUZZ_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .pontos_time0(pontos_time0), .pontos_time1(pontos_time1),
    .atualizar(atualizar), .erro(erro),
    .segmentos(segmentos), .anodos(anodos), .ocupado(ocupado),
    .estouro(estouro), .buzzer(buzzer)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge at which reset is released: four digits, 4 clocks each.
  task automatic scan_check(input string tag);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk({tag, "_an"}, 32'(anodos), 32'(an_pat[(k-1)/4]));
      chk({tag, "_seg"}, 32'(segmentos), 32'(seg_rst[(k-1)/4]));
    end
  endtask

  task automatic wait_digit(input string tag, input logic [3:0] pat, input logic [6:0] seg);
    bit found = 0;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (anodos == pat) begin
        found = 1;
        break;
      end
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
    if (found) chk(tag, 32'(segmentos), 32'(seg));
  endtask

  // Strobe once and count busy cycles; optionally change scores and
  // strobe again mid-conversion.
  task automatic strobe_count(input bit second, input logic [6:0] a2,
                              input logic [6:0] b2, output int hi, output bit gap);
    bit seen_low = 0;
    hi  = 0;
    gap = 0;
    @(negedge clk); atualizar = 1'b1;
    @(negedge clk); atualizar = 1'b0;
    for (int j = 0; j < 30; j++) begin
      if (ocupado) begin
        hi++;
        if (seen_low) gap = 1;
      end else begin
        seen_low = 1;
      end
      if (second && j == 2) begin pontos_time0 = a2; pontos_time1 = b2; end
      if (second && j == 3) atualizar = 1'b1;
      if (second && j == 4) atualizar = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_seg"}, 32'(segmentos), 32'(SEG_BLANK));
    chk({tag, "_an"}, 32'(anodos), 32'h0f);
    chk({tag, "_ocup"}, 32'(ocupado), 32'd0);
    chk({tag, "_estouro"}, 32'(estouro), 32'd0);
    chk({tag, "_buzzer"}, 32'(buzzer), 32'd0);
  endtask

  initial begin
    int  hi;
    bit  gap;
    an_pat  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_rst = '{SEG_BLANK, SEG_0, SEG_BLANK, SEG_0};
    rst_n = 1'b0;
    pontos_time0 = 7'd0;
    pontos_time1 = 7'd0;
    atualizar = 1'b0;
    erro = 1'b0;

    // Reset state and idle scan.
    repeat (3) @(negedge clk);
    reset_values("rst");
    rst_n = 1'b1;
    scan_check("scan_rst");
    chk("estouro_rst", 32'(estouro), 32'd0);

    // 37 / 8.
    pontos_time0 = 7'd37;
    pontos_time1 = 7'd8;
    strobe_count(1'b0, 7'd0, 7'd0, hi, gap);
    chk("busy_37_8", 32'(hi), 32'd8);
    chk("busy_gap_37_8", 32'(gap), 32'd0);
    wait_digit("d0_37", 4'b1110, SEG_3);
    wait_digit("d1_37", 4'b1101, SEG_7);
    wait_digit("d2_8", 4'b1011, SEG_BLANK);
    wait_digit("d3_8", 4'b0111, SEG_8);
    chk("estouro_37_8", 32'(estouro), 32'd0);

    // 99 / 127: saturation on team 1 only.
    pontos_time0 = 7'd99;
    pontos_time1 = 7'd127;
    strobe_count(1'b0, 7'd0, 7'd0, hi, gap);
    chk("busy_99_127", 32'(hi), 32'd8);
    wait_digit("d0_99", 4'b1110, SEG_9);
    wait_digit("d1_99", 4'b1101, SEG_9);
    wait_digit("d2_127", 4'b1011, SEG_9);
    wait_digit("d3_127", 4'b0111, SEG_9);
    chk("estouro_99_127", 32'(estouro), 32'b10);

    // Pending restart: scores 12/45 picked up at the first GRAVA.
    pontos_time0 = 7'd20;
    pontos_time1 = 7'd30;
    strobe_count(1'b1, 7'd12, 7'd45, hi, gap);
    chk("busy_pend", 32'(hi), 32'd16);
    chk("busy_gap_pend", 32'(gap), 32'd0);
    wait_digit("d0_12", 4'b1110, SEG_1);
    wait_digit("d1_12", 4'b1101, SEG_2);
    wait_digit("d2_45", 4'b1011, SEG_4);
    wait_digit("d3_45", 4'b0111, SEG_5);
    chk("estouro_pend", 32'(estouro), 32'd0);

    // Buzzer: erro held high gives one 5-cycle pulse.
    @(negedge clk); erro = 1'b1;
    hi = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (buzzer) hi++;
    end
    chk("buzz_held", 32'(hi), 32'd5);
    erro = 1'b0;
    repeat (10) @(negedge clk);
    chk("buzz_idle", 32'(buzzer), 32'd0);

    // Buzzer retrigger: 3 cycles into the pulse a new edge reloads it.
    erro = 1'b1;
    hi = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (buzzer) hi++;
      if (j == 1) erro = 1'b0;
      if (j == 2) erro = 1'b1;
    end
    chk("buzz_retrig", 32'(hi), 32'd8);
    erro = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during conversion.
    pontos_time0 = 7'd55;
    pontos_time1 = 7'd66;
    @(negedge clk); atualizar = 1'b1;
    @(negedge clk); atualizar = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_rst", 32'(ocupado), 32'd1);
    #1 rst_n = 1'b0;
    #1 reset_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    scan_check("scan_after_rst");
    chk("ocup_after_rst", 32'(ocupado), 32'd0);
    chk("estouro_after_rst", 32'(estouro), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
